// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, asynchronous-read instruction memory
// with a debug write port, IF/ID latch and a two-state FETCH/HALTED control FSM.
// Pipeline state moves only on edges with i_step=1. Reset and memory writes
// act on every edge regardless of i_step.
module if_stage #(
    parameter int BITS_SIZE  = 32,
    parameter int IMEM_DEPTH = 256,
    localparam int IDX       = $clog2(IMEM_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_step,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [BITS_SIZE-1:0] i_branch_addr,
    input  logic                 i_jump,
    input  logic [BITS_SIZE-1:0] i_jump_addr,
    input  logic                 i_imem_wr_en,
    input  logic [IDX-1:0]       i_imem_wr_addr,
    input  logic [BITS_SIZE-1:0] i_imem_wr_data,
    output logic [BITS_SIZE-1:0] o_pc,
    output logic [BITS_SIZE-1:0] o_pc4,
    output logic [BITS_SIZE-1:0] o_pc8,
    output logic [BITS_SIZE-1:0] o_instruction,
    output logic                 o_halted,
    output logic [BITS_SIZE-1:0] o_fetch_count
);

    localparam logic [BITS_SIZE-1:0] C_FOUR  = BITS_SIZE'(4);
    localparam logic [BITS_SIZE-1:0] C_EIGHT = BITS_SIZE'(8);
    localparam logic [5:0]           C_HALT_OPCODE = 6'b111111;

    typedef enum logic {
        S_FETCH  = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [BITS_SIZE-1:0] r_imem [IMEM_DEPTH];

    logic [BITS_SIZE-1:0] r_pc;
    logic [BITS_SIZE-1:0] r_pc4;
    logic [BITS_SIZE-1:0] r_pc8;
    logic [BITS_SIZE-1:0] r_instruction;
    logic [BITS_SIZE-1:0] r_fetch_count;

    logic [IDX-1:0]       w_idx;
    logic [BITS_SIZE-1:0] w_fetch_word;
    logic                 w_is_halt;
    logic                 w_redirect;
    logic [BITS_SIZE-1:0] w_redirect_pc;
    logic                 w_fetch_ok;
    logic                 w_unused;

    // Word-aligned fetch index; upper PC bits fall off so the index wraps.
    assign w_idx         = r_pc[IDX+1:2];
    assign w_fetch_word  = r_imem[w_idx];
    assign w_is_halt     = (w_fetch_word[31:26] == C_HALT_OPCODE);

    // Branch outranks jump; both targets are forced word aligned.
    assign w_redirect    = i_branch_taken | i_jump;
    assign w_redirect_pc = i_branch_taken ? {i_branch_addr[BITS_SIZE-1:2], 2'b00}
                                          : {i_jump_addr[BITS_SIZE-1:2], 2'b00};

    // A real fetch happens only in FETCH, with no redirect and no stall.
    assign w_fetch_ok    = i_step && !w_redirect && (r_state == S_FETCH) && !i_stall;

    // Low address bits of redirect targets are deliberately ignored.
    assign w_unused      = ^{i_branch_addr[1:0], i_jump_addr[1:0]};

    // Debug program load: written on any edge, never cleared, so a fetch of the
    // same word sees the new data one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_imem_wr_en) begin
            r_imem[i_imem_wr_addr] <= i_imem_wr_data;
        end
    end

    // FSM state register; reset returns to FETCH.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: redirects always resume fetching; a fetched HALT word
    // parks the stage. A HALT seen on a redirect edge is ignored.
    always_comb begin
        w_state_next = r_state;
        if (i_step) begin
            if (w_redirect) begin
                w_state_next = S_FETCH;
            end else if (w_fetch_ok && w_is_halt) begin
                w_state_next = S_HALTED;
            end
        end
    end

    // PC, IF/ID latch and fetch counter; priority reset > redirect > halted >
    // stall > normal fetch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc          <= '0;
            r_pc4         <= '0;
            r_pc8         <= '0;
            r_instruction <= '0;
            r_fetch_count <= '0;
        end else if (i_step) begin
            if (w_redirect) begin
                r_pc          <= w_redirect_pc;
                r_pc4         <= '0;
                r_pc8         <= '0;
                r_instruction <= '0;
            end else if (r_state == S_HALTED) begin
                r_pc4         <= '0;
                r_pc8         <= '0;
                r_instruction <= '0;
            end else if (!i_stall) begin
                r_pc4         <= r_pc + C_FOUR;
                r_pc8         <= r_pc + C_EIGHT;
                r_instruction <= w_fetch_word;
                r_fetch_count <= r_fetch_count + 1'b1;
                if (!w_is_halt) begin
                    r_pc <= r_pc + C_FOUR;
                end
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_pc4         = r_pc4;
    assign o_pc8         = r_pc8;
    assign o_instruction = r_instruction;
    assign o_fetch_count = r_fetch_count;
    assign o_halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized traffic, all
// checked against a behavioural model of the fetch rules.
module tb_if_stage;

    localparam int W     = 32;
    localparam int DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          step = 1'b0;
    logic          stall = 1'b0;
    logic          br = 1'b0;
    logic [W-1:0]  br_addr = '0;
    logic          jmp = 1'b0;
    logic [W-1:0]  jmp_addr = '0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_addr = '0;
    logic [W-1:0]  wr_data = '0;

    logic [W-1:0]  o_pc, o_pc4, o_pc8, o_instruction, o_fetch_count;
    logic          o_halted;

    if_stage #(.BITS_SIZE(W), .IMEM_DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_step         (step),
        .i_stall        (stall),
        .i_branch_taken (br),
        .i_branch_addr  (br_addr),
        .i_jump         (jmp),
        .i_jump_addr    (jmp_addr),
        .i_imem_wr_en   (wr_en),
        .i_imem_wr_addr (wr_addr),
        .i_imem_wr_data (wr_data),
        .o_pc           (o_pc),
        .o_pc4          (o_pc4),
        .o_pc8          (o_pc8),
        .o_instruction  (o_instruction),
        .o_halted       (o_halted),
        .o_fetch_count  (o_fetch_count)
    );

    // ---------------- reference model ----------------
    logic [W-1:0] m_mem [DEPTH];
    logic [W-1:0] m_pc, m_pc4, m_pc8, m_inst, m_count;
    logic         m_halted;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_value(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[27] = 1'b0;
        return w;
    endfunction

    // ---------------- driver ----------------
    // One clock edge: drive inputs, advance the model, then compare every
    // output 1 time unit after the edge.
    task automatic tick(input logic i_rst, input logic i_step, input logic i_stall,
                        input logic i_br, input logic [W-1:0] i_baddr,
                        input logic i_jmp, input logic [W-1:0] i_jaddr,
                        input logic i_we, input logic [7:0] i_wa, input logic [W-1:0] i_wd);
        logic [W-1:0] word;
        reset = i_rst; step = i_step; stall = i_stall;
        br = i_br; br_addr = i_baddr; jmp = i_jmp; jmp_addr = i_jaddr;
        wr_en = i_we; wr_addr = i_wa; wr_data = i_wd;

        if (i_rst) begin
            m_pc = '0; m_pc4 = '0; m_pc8 = '0; m_inst = '0; m_count = '0; m_halted = 1'b0;
        end else if (i_step) begin
            if (i_br || i_jmp) begin
                m_pc = i_br ? (i_baddr & ~32'h3) : (i_jaddr & ~32'h3);
                m_pc4 = '0; m_pc8 = '0; m_inst = '0; m_halted = 1'b0;
            end else if (m_halted) begin
                m_pc4 = '0; m_pc8 = '0; m_inst = '0;
            end else if (!i_stall) begin
                word    = m_mem[(m_pc / 4) % DEPTH];
                m_pc4   = m_pc + 4;
                m_pc8   = m_pc + 8;
                m_inst  = word;
                m_count = m_count + 1;
                if (word[31:26] == 6'h3F) m_halted = 1'b1;
                else m_pc = m_pc + 4;
            end
        end
        if (i_we) m_mem[i_wa] = i_wd;

        exp_q.push_back(m_pc);
        exp_q.push_back(m_pc4);
        exp_q.push_back(m_pc8);
        exp_q.push_back(m_inst);
        exp_q.push_back(m_count);
        exp_q.push_back({31'b0, m_halted});

        @(posedge clk);
        #1;
        check_value("pc", o_pc, exp_q.pop_front());
        check_value("pc4", o_pc4, exp_q.pop_front());
        check_value("pc8", o_pc8, exp_q.pop_front());
        check_value("instruction", o_instruction, exp_q.pop_front());
        check_value("fetch_count", o_fetch_count, exp_q.pop_front());
        check_value("halted", {31'b0, o_halted}, exp_q.pop_front());
    endtask

    task automatic run(input int n);
        repeat (n) tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic jump_to(input logic [W-1:0] addr);
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, addr, 1'b0, '0, '0);
    endtask

    task automatic write_word(input logic [7:0] idx, input logic [W-1:0] data);
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, idx, data);
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] saved_inst, saved_count;

    initial begin
        // Reset state
        do_reset();
        check_value("rst_pc", o_pc, 32'h0);
        check_value("rst_count", o_fetch_count, 32'h0);
        check_value("rst_halted", {31'b0, o_halted}, 32'h0);

        // Program load with the pipeline frozen
        for (int i = 0; i < DEPTH; i++) write_word(8'(i), rand_word());
        write_word(8'd0, 32'h20010005);
        write_word(8'd1, 32'h20020007);
        write_word(8'd2, 32'hFC000000);

        // Three fetches ending in HALT, then a bubble
        do_reset();
        run(1); check_value("seq_i0", o_instruction, 32'h20010005);
        run(1); check_value("seq_i1", o_instruction, 32'h20020007);
        run(1); check_value("seq_i2", o_instruction, 32'hFC000000);
        run(1);
        check_value("seq_i3", o_instruction, 32'h0);
        check_value("seq_pc", o_pc, 32'h8);
        check_value("seq_halted", {31'b0, o_halted}, 32'h1);
        check_value("seq_count", o_fetch_count, 32'h3);

        // Jump out of HALTED
        jump_to(32'h0);
        check_value("unhalt_halted", {31'b0, o_halted}, 32'h0);
        check_value("unhalt_pc", o_pc, 32'h0);
        run(1);
        check_value("resume_inst", o_instruction, 32'h20010005);
        check_value("resume_pc", o_pc, 32'h4);

        // Stall at PC=0x10
        jump_to(32'h0C);
        run(1);
        saved_inst = m_inst; saved_count = m_count;
        repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        check_value("stall_pc", o_pc, 32'h10);
        check_value("stall_inst", o_instruction, saved_inst);
        check_value("stall_count", o_fetch_count, saved_count);
        run(1);
        check_value("release_pc", o_pc, 32'h14);

        // Branch beats jump on the same edge
        jump_to(32'h20);
        saved_count = m_count;
        tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h43, 1'b1, 32'h80, 1'b0, '0, '0);
        check_value("brj_pc", o_pc, 32'h40);
        check_value("brj_inst", o_instruction, 32'h0);
        check_value("brj_count", o_fetch_count, saved_count);

        // Frozen pipeline while writing index 5, then fetch it
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 8'd5, 32'hA5A51234);
        check_value("freeze_pc", o_pc, 32'h40);
        jump_to(32'h14);
        run(1);
        check_value("wr_fetch", o_instruction, 32'hA5A51234);

        // Write to the addressed word is seen one cycle later
        tick(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 8'd6, 32'h12345678);
        run(1);
        check_value("wr_next_cycle", o_instruction, 32'h12345678);

        // Reset while HALTED with count 7
        write_word(8'd2, 32'h00000022);
        write_word(8'd6, 32'hFC000000);
        do_reset();
        run(7);
        check_value("h7_halted", {31'b0, o_halted}, 32'h1);
        check_value("h7_count", o_fetch_count, 32'h7);
        do_reset();
        check_value("h7_rst_pc", o_pc, 32'h0);
        check_value("h7_rst_count", o_fetch_count, 32'h0);
        check_value("h7_rst_halted", {31'b0, o_halted}, 32'h0);
        run(1);
        check_value("h7_retained", o_instruction, 32'h20010005);

        // PC wrap at the top of the address space
        jump_to(32'hFFFFFFFF);
        check_value("wrap_target", o_pc, 32'hFFFFFFFC);
        if (m_halted == 1'b0) begin
            run(1);
            check_value("wrap_pc", o_pc, 32'h0);
            check_value("wrap_pc8", o_pc8, 32'h4);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] wd;
            wd = ($urandom_range(0, 15) == 0) ? {6'h3F, 26'($urandom)} : rand_word();
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 3) == 0, 8'($urandom), wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter BITS_SIZE, default 32, meaning datapath/PC width.
REQ-002 Parameter IMEM_DEPTH, default 256, meaning instruction memory words (power of 2); IDX = log2(IMEM_DEPTH).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: i_clk  in  1  rising-edge clock.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 i_step  in  1  pipeline advance enable; low = all pipeline state holds.
REQ-006 i_stall  in  1  load-use stall from hazard unit.
REQ-007 i_branch_taken  in  1; i_branch_addr  in  BITS_SIZE  resolved branch redirect.
REQ-008 i_jump  in  1; i_jump_addr  in  BITS_SIZE  jump/jr/jal redirect.
REQ-009 i_imem_wr_en  in  1; i_imem_wr_addr  in  IDX  word index; i_imem_wr_data  in  BITS_SIZE  debug program load.
REQ-010 o_pc  out  BITS_SIZE  current fetch PC.
REQ-011 o_pc4, o_pc8, o_instruction  out  BITS_SIZE each  IF/ID latch contents feeding the decode stage.
REQ-012 o_halted  out  1  fetch halted; o_fetch_count  out  BITS_SIZE  instructions latched into IF/ID.

Function
REQ-013 Instruction memory SHALL be IMEM_DEPTH x BITS_SIZE, read asynchronously at index pc[IDX+1:2]; index wraps modulo IMEM_DEPTH.
REQ-014 Memory write SHALL occur on any clock edge with i_imem_wr_en=1, independent of i_step, state and i_reset; contents are not cleared by reset.
REQ-015 A write to the currently addressed word SHALL be visible to the fetch on the following cycle, not the same cycle.
REQ-016 State machine: FETCH, HALTED; reset enters FETCH.
REQ-017 All updates below SHALL happen only on edges with i_step=1; priority: reset > branch > jump > HALTED > stall > normal.
REQ-018 Branch (i_branch_taken=1): PC <= {i_branch_addr[BITS_SIZE-1:2],2'b00}; IF/ID cleared to zero; state <= FETCH; count unchanged.
REQ-019 Jump (i_jump=1, no branch): PC <= {i_jump_addr[BITS_SIZE-1:2],2'b00}; IF/ID cleared; state <= FETCH; count unchanged.
REQ-020 HALTED with no redirect: PC holds; IF/ID cleared (NOP bubbles); count holds.
REQ-021 Stall in FETCH with no redirect: PC, IF/ID, count all hold.
REQ-022 Normal fetch: o_pc4 <= PC+4, o_pc8 <= PC+8, o_instruction <= imem[idx], PC <= PC+4 (mod 2^BITS_SIZE), count <= count+1 (wraps).
REQ-023 If the fetched word has opcode [31:26]=6'b111111 (HALT), it SHALL be latched normally, PC SHALL NOT advance, and state <= HALTED.
REQ-024 A HALT word fetched on a redirect edge SHALL be discarded and SHALL NOT change state.
REQ-025 o_halted SHALL be 1 exactly when state = HALTED.
REQ-026 PC overflow 0xFFFFFFFC+4 SHALL wrap to 0 with no flag.

Reset
REQ-027 On i_reset=1 edge (regardless of i_step): PC=0, o_pc4=o_pc8=o_instruction=0, o_fetch_count=0, state FETCH, o_halted=0.
REQ-028 Reset mid-stall, mid-halt or coincident with a redirect SHALL yield exactly the REQ-027 values the next cycle.

Verification
REQ-029 Load imem[0..2]=0x20010005,0x20020007,0xFC000000, step 4 cycles -> o_instruction 0x20010005,0x20020007,0xFC000000,0; o_pc=8 held; o_halted=1; count=3.
REQ-030 Running at PC=0x10, i_stall=1 for 2 steps -> o_pc stays 0x10, IF/ID and count unchanged; release -> o_pc=0x14.
REQ-031 PC=0x20, i_branch_taken=1 addr 0x43 and i_jump=1 addr 0x80 same edge -> o_pc=0x40, o_instruction=0, count unchanged.
REQ-032 HALTED at PC=0x08, i_jump=1 addr 0x00 -> o_halted=0, o_pc=0x00, fetch resumes.
REQ-033 i_step=0 for 3 cycles with imem write to index 5 -> PC/IF/ID unchanged; later fetch at 0x14 returns written data.
REQ-034 i_reset=1 while HALTED with count=7 -> next cycle o_pc=0, count=0, o_halted=0, imem contents retained.
